// File: rtl/mem_arbiter_rr.sv
// N-channel arbiter in front of a single line-memory port: latches one winning
// request (round-robin or fixed priority), issues it, and routes the completion back.
module mem_arbiter_rr #(
  parameter int NUM_REQ  = 2,
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 256,
  parameter int ARB_MODE = 0,
  parameter int IDX_W    = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [DATA_W-1:0]         req_rdata,
  output logic [NUM_REQ-1:0]        req_resp,
  output logic [ADDR_W-1:0]         mem_addr,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_wdata,
  input  logic                      mem_ready,
  input  logic [DATA_W-1:0]         mem_rdata,
  input  logic                      mem_resp,
  output logic                      grant_valid,
  output logic [IDX_W-1:0]          grant_idx
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;

  localparam logic [IDX_W:0] LP_N = (IDX_W+1)'(NUM_REQ);

  state_t              r_state, w_state_nxt;
  logic [IDX_W-1:0]    r_idx, r_rr_ptr;
  logic                r_wr;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_wdata;

  logic [NUM_REQ-1:0]  w_req;
  logic [IDX_W-1:0]    w_start, w_win_idx, w_rr_nxt;
  logic [IDX_W:0]      w_cand, w_inc;
  logic                w_win_vld;

  assign w_req = req_read | req_write;

  // Rotating search from the start index; fixed priority always starts at 0.
  always_comb begin
    w_start   = (ARB_MODE == 1) ? '0 : r_rr_ptr;
    w_win_vld = 1'b0;
    w_win_idx = '0;
    w_cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_cand = {1'b0, w_start} + (IDX_W+1)'(i);
      if (w_cand >= LP_N) w_cand = w_cand - LP_N;
      if (!w_win_vld && w_req[w_cand[IDX_W-1:0]]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_inc    = {1'b0, r_idx} + (IDX_W+1)'(1);
  assign w_rr_nxt = (w_inc == LP_N) ? '0 : w_inc[IDX_W-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    req_resp    = '0;
    req_rdata   = '0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    case (r_state)
      S_IDLE: begin
        if (w_win_vld) w_state_nxt = S_ISSUE;
      end
      S_ISSUE: begin
        mem_read    = ~r_wr;
        mem_write   = r_wr;
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        grant_valid = 1'b1;
        grant_idx   = r_idx;
        if (mem_ready) w_state_nxt = S_WAIT;
      end
      S_WAIT: begin
        mem_addr    = r_addr;
        mem_wdata   = r_wdata;
        grant_valid = 1'b1;
        grant_idx   = r_idx;
        if (mem_resp) begin
          req_resp[r_idx] = 1'b1;
          req_rdata       = mem_rdata;
          w_state_nxt     = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Request is captured once at grant; later changes on the channel are ignored.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_idx    <= '0;
      r_wr     <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (r_state == S_IDLE && w_win_vld) begin
        r_idx   <= w_win_idx;
        r_wr    <= req_write[w_win_idx];
        r_addr  <= req_addr[w_win_idx*ADDR_W +: ADDR_W];
        r_wdata <= req_wdata[w_win_idx*DATA_W +: DATA_W];
      end
      if (r_state == S_WAIT && mem_resp) r_rr_ptr <= w_rr_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// Two arbiters (round-robin and fixed priority, 4 channels) under random traffic,
// each checked cycle by cycle against a queue of expected outputs from a reference model.
module tb_mem_arbiter_rr;

  localparam int N  = 4;
  localparam int AW = 32;
  localparam int DW = 64;

  typedef struct {
    logic          rd, wr, gv;
    logic [1:0]    gidx;
    logic [N-1:0]  resp;
    logic [DW-1:0] rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    bit            chk_a, chk_w;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic            rst_n     [2];
  logic [N*AW-1:0] req_addr  [2];
  logic [N-1:0]    req_read  [2];
  logic [N-1:0]    req_write [2];
  logic [N*DW-1:0] req_wdata [2];
  logic [DW-1:0]   req_rdata [2];
  logic [N-1:0]    req_resp  [2];
  logic [AW-1:0]   mem_addr  [2];
  logic            mem_read  [2];
  logic            mem_write [2];
  logic [DW-1:0]   mem_wdata [2];
  logic            mem_ready [2];
  logic [DW-1:0]   mem_rdata [2];
  logic            mem_resp  [2];
  logic            grant_valid [2];
  logic [1:0]      grant_idx [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_arbiter_rr #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .ARB_MODE(g)) u_dut (
      .clk(clk), .rst_n(rst_n[g]),
      .req_addr(req_addr[g]), .req_read(req_read[g]), .req_write(req_write[g]),
      .req_wdata(req_wdata[g]), .req_rdata(req_rdata[g]), .req_resp(req_resp[g]),
      .mem_addr(mem_addr[g]), .mem_read(mem_read[g]), .mem_write(mem_write[g]),
      .mem_wdata(mem_wdata[g]), .mem_ready(mem_ready[g]), .mem_rdata(mem_rdata[g]),
      .mem_resp(mem_resp[g]), .grant_valid(grant_valid[g]), .grant_idx(grant_idx[g])
    );
  end

  // Reference model state per environment (0 = round-robin, 1 = fixed priority)
  logic [N-1:0]         pend  [2];
  logic [N-1:0][1:0]    pop   [2];   // 0 read, 1 write, 2 read+write
  logic [N-1:0][AW-1:0] paddr [2];
  logic [N-1:0][DW-1:0] pwd   [2];
  int  ph [2];      // 0 idle, 1 command outstanding, 2 awaiting completion
  int  cnt [2], own [2], rr [2];
  int  fr_rdy [2], fr_resp [2];
  bit  fr_a5 [2], fresh [2], done [2];
  exp_t q0[$], q1[$];

  task automatic push(input int g, input exp_t e);
    if (g == 0) q0.push_back(e); else q1.push_back(e);
  endtask

  task automatic step(input int g, input bit rst_lo, input bit stray, input int prob);
    exp_t e;
    bit acc, rsp;
    int st, c;
    logic [DW-1:0] rd;
    for (int k = 0; k < N; k++) begin
      if (!pend[g][k] && $urandom_range(99) < prob) begin
        pend[g][k]  = 1'b1;
        pop[g][k]   = 2'($urandom_range(2));
        paddr[g][k] = $urandom;
        pwd[g][k]   = {$urandom, $urandom};
      end
    end
    for (int k = 0; k < N; k++) begin
      if (ph[g] != 0 && k == own[g]) begin
        req_read[g][k]           = 1'($urandom_range(1));
        req_write[g][k]          = 1'($urandom_range(1));
        req_addr[g][k*AW +: AW]  = $urandom;
        req_wdata[g][k*DW +: DW] = {$urandom, $urandom};
      end else if (pend[g][k]) begin
        req_read[g][k]           = (pop[g][k] != 2'd1);
        req_write[g][k]          = (pop[g][k] != 2'd0);
        req_addr[g][k*AW +: AW]  = paddr[g][k];
        req_wdata[g][k*DW +: DW] = pwd[g][k];
      end else begin
        req_read[g][k]           = 1'b0;
        req_write[g][k]          = 1'b0;
        req_addr[g][k*AW +: AW]  = $urandom;
        req_wdata[g][k*DW +: DW] = {$urandom, $urandom};
      end
    end
    acc = 1'b0;
    rsp = 1'b0;
    rd  = {$urandom, $urandom};
    case (ph[g])
      1: begin
        acc          = (cnt[g] == 0);
        mem_ready[g] = acc;
        mem_resp[g]  = acc & 1'($urandom_range(1));
      end
      2: begin
        mem_ready[g] = 1'($urandom_range(1));
        rsp          = (cnt[g] == 0) && !rst_lo;
        mem_resp[g]  = rsp;
      end
      default: begin
        mem_ready[g] = 1'($urandom_range(1));
        mem_resp[g]  = stray;
      end
    endcase
    if (rsp && fr_a5[g]) begin
      rd       = {8{8'hA5}};
      fr_a5[g] = 1'b0;
    end
    mem_rdata[g] = rd;
    rst_n[g]     = !rst_lo;

    e.rd = 1'b0; e.wr = 1'b0; e.gv = 1'b0; e.gidx = '0; e.resp = '0; e.rdata = '0;
    e.addr = '0; e.wdata = '0; e.chk_a = fresh[g]; e.chk_w = fresh[g];
    if (ph[g] != 0) begin
      e.gv    = 1'b1;
      e.gidx  = 2'(own[g]);
      e.addr  = paddr[g][own[g]];
      e.chk_a = 1'b1;
    end
    if (ph[g] == 1) begin
      e.rd    = (pop[g][own[g]] == 2'd0);
      e.wr    = (pop[g][own[g]] != 2'd0);
      e.wdata = pwd[g][own[g]];
      e.chk_w = 1'b1;
    end
    if (rsp) begin
      e.resp  = N'(1) << own[g];
      e.rdata = rd;
    end
    push(g, e);

    if (rst_lo) begin
      ph[g] = 0; rr[g] = 0; fresh[g] = 1'b1;
    end else begin
      case (ph[g])
        0: if (pend[g] != '0) begin
          st = (g == 1) ? 0 : rr[g];
          for (int i = N - 1; i >= 0; i--) begin
            c = (st + i) % N;
            if (pend[g][c]) own[g] = c;
          end
          ph[g]    = 1;
          fresh[g] = 1'b0;
          cnt[g]   = (fr_rdy[g] >= 0) ? fr_rdy[g] : int'($urandom_range(3));
          fr_rdy[g] = -1;
        end
        1: if (acc) begin
          ph[g]  = 2;
          cnt[g] = (fr_resp[g] >= 0) ? fr_resp[g] : int'($urandom_range(5));
          fr_resp[g] = -1;
        end else cnt[g]--;
        default: if (rsp) begin
          pend[g][own[g]] = 1'b0;
          rr[g] = (own[g] + 1) % N;
          ph[g] = 0;
        end else cnt[g]--;
      endcase
    end
  endtask

  task automatic cyc(input int g, input bit rst_lo, input bit stray, input int prob);
    @(negedge clk);
    step(g, rst_lo, stray, prob);
  endtask

  task automatic run(input int g);
    pend[g] = '0; pop[g] = '0; paddr[g] = '0; pwd[g] = '0;
    ph[g] = 0; cnt[g] = 0; own[g] = 0; rr[g] = 0; fresh[g] = 1'b1;
    fr_rdy[g] = -1; fr_resp[g] = -1; fr_a5[g] = 1'b0; done[g] = 1'b0;
    rst_n[g] = 1'b0; req_addr[g] = '0; req_read[g] = '0; req_write[g] = '0;
    req_wdata[g] = '0; mem_ready[g] = 1'b0; mem_rdata[g] = '0; mem_resp[g] = 1'b0;
    @(posedge clk);
    repeat (2) cyc(g, 1'b1, 1'b0, 0);
    repeat (10) cyc(g, 1'b0, 1'b0, 0);
    // Directed single read on channel 1: accepted after 3 command cycles, answered 5 later
    pend[g][1] = 1'b1; pop[g][1] = 2'd0; paddr[g][1] = 32'h0000_1040; pwd[g][1] = '0;
    fr_rdy[g] = 2; fr_resp[g] = 4; fr_a5[g] = 1'b1;
    repeat (12) cyc(g, 1'b0, 1'b0, 0);
    for (int i = 0; i < 1500; i++) cyc(g, 1'b0, 1'b0, ((i / 200) % 2 == 1) ? 100 : 30);
    // Abandon a transaction with reset while all channels hold requests
    for (int i = 0; i < 50 && ph[g] != 2; i++) cyc(g, 1'b0, 1'b0, 100);
    cyc(g, 1'b1, 1'b0, 100);
    cyc(g, 1'b1, 1'b0, 100);
    cyc(g, 1'b0, 1'b1, 100);
    for (int i = 0; i < 1000; i++) cyc(g, 1'b0, 1'b0, 100);
    repeat (40) cyc(g, 1'b0, 1'b0, 0);
    done[g] = 1'b1;
  endtask

  initial run(0);
  initial run(1);

  task automatic chk(input int g, input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL env%0d %s: got %0h, want %0h (t=%0t)", g, name, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      for (int g = 0; g < 2; g++) begin
        if ((g == 0) ? (q0.size() > 0) : (q1.size() > 0)) begin
          e = (g == 0) ? q0.pop_front() : q1.pop_front();
          chk(g, "mem_read",    DW'(mem_read[g]),    DW'(e.rd));
          chk(g, "mem_write",   DW'(mem_write[g]),   DW'(e.wr));
          chk(g, "grant_valid", DW'(grant_valid[g]), DW'(e.gv));
          chk(g, "grant_idx",   DW'(grant_idx[g]),   DW'(e.gidx));
          chk(g, "req_resp",    DW'(req_resp[g]),    DW'(e.resp));
          chk(g, "req_rdata",   req_rdata[g],        e.rdata);
          if (e.chk_a) chk(g, "mem_addr", DW'(mem_addr[g]), DW'(e.addr));
          if (e.chk_w) chk(g, "mem_wdata", mem_wdata[g], e.wdata);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk);
      if (done[0] && done[1]) break;
    end
    if (!(done[0] && done[1])) begin
      $display("FAIL timeout: stimulus did not complete within cycle budget");
      $fatal(1, "timeout");
    end
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
